keypad_scanner: RTL

- Upstream stage of the keypad decoder. Drives the 4x4 matrix rows one-hot, samples the four column lines and debounces them.
- Emits a one-hot {row,col} 8-bit code with a single-cycle valid strobe.
- key_code bit order matches the decoder's pin ordering: bits[7:4] = row one-hot (pin1..pin4), bits[3:0] = column one-hot (pin5..pin8).

---
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: drives rows one-hot, synchronizes and samples the columns,
// and debounces whole-matrix scans into a single accepted one-hot {row,col} key code.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_TARGET  = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PEND     = 2'd1,
    S_PRESSED  = 2'd2,
    S_REL_PEND = 2'd3
  } state_t;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_s;
  logic [CW-1:0] r_settle;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row_drive;
  logic [15:0]   r_samp;
  state_t        r_state;
  logic [DW-1:0] r_cnt;
  logic [7:0]    r_cand;
  logic [7:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  logic          w_sample;
  logic          w_scan_done;
  logic [15:0]   w_scan;
  logic          w_scan_none;
  logic          w_scan_single;
  logic [7:0]    w_scan_code;
  logic [DW-1:0] w_cnt_inc;
  state_t        w_state_next;
  logic [DW-1:0] w_cnt_next;
  logic [7:0]    w_cand_next;
  logic          w_accept;
  logic          w_held_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_meta <= 4'd0;
      r_col_s    <= 4'd0;
    end else begin
      r_col_meta <= col_in;
      r_col_s    <= r_col_meta;
    end
  end

  assign w_sample    = (r_settle == SETTLE_LAST);
  assign w_scan_done = w_sample && (r_row_idx == 2'd3);

  // Row samples are packed row 0 in the top nibble so the scan lines up with the code layout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle    <= CW'(0);
      r_row_idx   <= 2'd0;
      r_row_drive <= 4'b1000;
      r_samp      <= 16'd0;
    end else if (w_sample) begin
      r_settle    <= CW'(0);
      r_row_idx   <= r_row_idx + 2'd1;
      r_row_drive <= {r_row_drive[0], r_row_drive[3:1]};
      r_samp[{~r_row_idx, 2'b00} +: 4] <= r_col_s;
    end else begin
      r_settle    <= r_settle + CW'(1);
    end
  end

  assign w_scan        = {r_samp[15:4], r_col_s};
  assign w_scan_none   = (w_scan == 16'd0);
  assign w_scan_single = is_onehot16(w_scan);
  assign w_scan_code   = {|w_scan[15:12], |w_scan[11:8], |w_scan[7:4], |w_scan[3:0],
                          w_scan[15:12] | w_scan[11:8] | w_scan[7:4] | w_scan[3:0]};
  assign w_cnt_inc     = r_cnt + DW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RELEASED;
      r_cnt   <= DW'(0);
      r_cand  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cand  <= w_cand_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    if (w_scan_done) begin
      case (r_state)
        S_RELEASED: begin
          if (w_scan_single) begin
            w_cand_next  = w_scan_code;
            w_cnt_next   = DW'(1);
            w_state_next = (DEBOUNCE_SCANS == 1) ? S_PRESSED : S_PEND;
          end else begin
            w_state_next = S_RELEASED;
          end
        end
        S_PEND: begin
          if (w_scan_single && (w_scan_code == r_cand)) begin
            w_cnt_next   = w_cnt_inc;
            w_state_next = (w_cnt_inc == DEB_TARGET) ? S_PRESSED : S_PEND;
          end else if (w_scan_single) begin
            w_cand_next  = w_scan_code;
            w_cnt_next   = DW'(1);
            w_state_next = S_PEND;
          end else begin
            w_cnt_next   = DW'(0);
            w_state_next = S_RELEASED;
          end
        end
        // Any activity while pressed keeps the key; a new key needs a full release first.
        S_PRESSED: begin
          if (w_scan_none) begin
            w_cnt_next   = DW'(1);
            w_state_next = (DEBOUNCE_SCANS == 1) ? S_RELEASED : S_REL_PEND;
          end else begin
            w_state_next = S_PRESSED;
          end
        end
        S_REL_PEND: begin
          if (w_scan_none) begin
            w_cnt_next   = w_cnt_inc;
            w_state_next = (w_cnt_inc == DEB_TARGET) ? S_RELEASED : S_REL_PEND;
          end else begin
            w_state_next = S_PRESSED;
          end
        end
        default: begin
          w_cnt_next   = DW'(0);
          w_state_next = S_RELEASED;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  always_comb begin
    w_accept    = 1'b0;
    w_held_next = (w_state_next == S_PRESSED) || (w_state_next == S_REL_PEND);
    if (w_scan_done && (w_state_next == S_PRESSED) &&
        ((r_state == S_RELEASED) || (r_state == S_PEND))) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_code  <= 8'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      r_key_held  <= w_held_next;
      if (w_accept) begin
        r_key_code <= w_cand_next;
      end
    end
  end

  assign row_drive = r_row_drive;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
